// File: rtl/expr_stream_check.sv
// Streaming recogniser for ASCII arithmetic expressions: multi-digit operands, nested parens, sticky error.
// Latency: 1 cycle from the byte being sampled to out/err/depth/terms reflecting it.
// Backpressure: none; accepts one byte per cycle whenever in_valid is high.
module expr_stream_check #(
    parameter int MAX_DEPTH  = 4,
    parameter int MAX_DIGITS = 3,
    parameter bit EXT_OPS    = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in,
    output logic       out,
    output logic       err,
    output logic [3:0] depth,
    output logic [7:0] terms
);

    localparam logic [3:0] DEPTH_LIM = 4'(MAX_DEPTH);
    localparam logic [3:0] DIG_LIM   = 4'(MAX_DIGITS);

    typedef enum logic [2:0] {
        S_START,
        S_NUM,
        S_VAL,
        S_OP,
        S_ERR
    } state_t;

    state_t     state;
    logic [3:0] dcnt;

    logic is_dig;
    logic is_op;
    logic is_lp;
    logic is_rp;
    logic is_sp;

    // '-' and '/' fall through to the error class unless the extended set is enabled
    always_comb begin
        is_dig = (in >= 8'h30) && (in <= 8'h39);
        is_op  = (in == 8'h2B) || (in == 8'h2A) ||
                 (EXT_OPS && ((in == 8'h2D) || (in == 8'h2F)));
        is_lp  = (in == 8'h28);
        is_rp  = (in == 8'h29);
        is_sp  = (in == 8'h20);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_START;
            depth <= 4'd0;
            dcnt  <= 4'd0;
            terms <= 8'd0;
        end else if (start) begin
            state <= S_START;
            depth <= 4'd0;
            dcnt  <= 4'd0;
            terms <= 8'd0;
        end else if (in_valid) begin
            case (state)
                S_START, S_OP: begin
                    if (is_dig) begin
                        state <= S_NUM;
                        dcnt  <= 4'd1;
                        if (terms != 8'hFF)
                            terms <= terms + 8'd1;
                    end else if (is_lp) begin
                        if (depth == DEPTH_LIM) begin
                            state <= S_ERR;
                        end else begin
                            depth <= depth + 4'd1;
                            state <= S_START;
                        end
                    end else if (!is_sp) begin
                        state <= S_ERR;
                    end
                end
                S_NUM: begin
                    if (is_dig) begin
                        if (dcnt == DIG_LIM)
                            state <= S_ERR;
                        else
                            dcnt <= dcnt + 4'd1;
                    end else if (is_op) begin
                        state <= S_OP;
                    end else if (is_rp) begin
                        if (depth == 4'd0) begin
                            state <= S_ERR;
                        end else begin
                            depth <= depth - 4'd1;
                            state <= S_VAL;
                        end
                    end else if (is_sp) begin
                        state <= S_VAL;
                    end else begin
                        state <= S_ERR;
                    end
                end
                S_VAL: begin
                    if (is_op) begin
                        state <= S_OP;
                    end else if (is_rp) begin
                        if (depth == 4'd0)
                            state <= S_ERR;
                        else
                            depth <= depth - 4'd1;
                    end else if (!is_sp) begin
                        state <= S_ERR;
                    end
                end
                default: begin
                    // error state is sticky until start or clr
                    state <= S_ERR;
                end
            endcase
        end
    end

    assign out = ((state == S_NUM) || (state == S_VAL)) && (depth == 4'd0);
    assign err = (state == S_ERR);

endmodule
